// File: rtl/vga_system_ram_dp.sv
// Dual-port frame/system RAM for the VGA subsystem.
//   s1 : Avalon-MM read/write slave with byte enables, read latency 1.
//   s2 : read-only scanout port, read latency 1, never stalls.
//   A clear engine fills the whole array with one word, stalling s1 while busy.
// Reads return the array contents from before any write landing on the same edge.
module vga_system_ram_dp #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  // s1: read/write slave
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  // s2: read-only scanout
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_read,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  // clear engine
  input  logic                clear_start,
  input  logic [DATA_W-1:0]   clear_value,
  output logic                clear_busy,
  output logic                clear_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // Clear engine state
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,        state_d;
  logic [ADDR_W-1:0] fill_ptr_q,     fill_ptr_d;
  logic [DATA_W-1:0] fill_value_q,   fill_value_d;
  logic              init_pending_q, init_pending_d;

  // ---------------------------------------------------------------------------
  // Read-side registers
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] s1_rdata_q;
  logic              s1_rvalid_q;
  logic [DATA_W-1:0] s2_rdata_q;
  logic              s2_rvalid_q;

  // ---------------------------------------------------------------------------
  // Write port selection
  // ---------------------------------------------------------------------------
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_wbe;

  // s1 handshake: a write wins over a simultaneous read; nothing is accepted
  // while the clear engine owns the array.
  logic s1_accept;
  logic s1_wr_accept;
  logic s1_rd_accept;

  assign s1_accept    = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
  assign s1_wr_accept = s1_accept & s1_write;
  assign s1_rd_accept = s1_accept & s1_read & ~s1_write;

  // Status outputs decode directly from the state register so reset clears
  // them immediately.
  assign clear_busy     = (state_q != ST_IDLE);
  assign clear_done     = (state_q == ST_DONE);
  assign s1_waitrequest = clear_busy;

  // Next-state logic of the clear engine.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    fill_ptr_d     = fill_ptr_q;
    fill_value_d   = fill_value_q;
    init_pending_d = init_pending_q;
    case (state_q)
      ST_IDLE: begin
        if (init_pending_q) begin
          // Power-up clear always fills with zero.
          state_d        = ST_FILL;
          fill_ptr_d     = '0;
          fill_value_d   = '0;
          init_pending_d = 1'b0;
        end else if (clear_start) begin
          state_d      = ST_FILL;
          fill_ptr_d   = '0;
          fill_value_d = clear_value;
        end
      end
      ST_FILL: begin
        fill_ptr_d = fill_ptr_q + ADDR_W'(1);
        if (fill_ptr_q == LAST_ADDR) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear engine registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      fill_ptr_q     <= '0;
      fill_value_q   <= '0;
      init_pending_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q        <= state_d;
      fill_ptr_q     <= fill_ptr_d;
      fill_value_q   <= fill_value_d;
      init_pending_q <= init_pending_d;
    end
  end

  // Single write port: the fill engine while filling, otherwise s1.
  // s1 cannot be accepted during a fill, so the two never collide.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s1_address;
    mem_wdata = s1_writedata;
    mem_wbe   = s1_byteenable;
    if (state_q == ST_FILL) begin
      mem_we    = 1'b1;
      mem_waddr = fill_ptr_q;
      mem_wdata = fill_value_q;
      mem_wbe   = {BYTES{1'b1}};
    end else if (s1_wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // Byte-masked array write.
  // NOTE: the array has no reset; contents survive reset and an aborted fill
  // leaves untouched words as they were.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mem_wbe[b]) begin
          mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // s1 read data path: data captured on acceptance, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_rdata_q  <= '0;
      s1_rvalid_q <= 1'b0;
    end else begin
      s1_rvalid_q <= s1_rd_accept;
      if (s1_rd_accept) begin
        s1_rdata_q <= mem_q[s1_address];
      end
    end
  end

  // s2 scanout read path: always serviced, independent of s1 and the fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_rdata_q  <= '0;
      s2_rvalid_q <= 1'b0;
    end else begin
      s2_rvalid_q <= s2_read;
      if (s2_read) begin
        s2_rdata_q <= mem_q[s2_address];
      end
    end
  end

  assign s1_readdata      = s1_rdata_q;
  assign s1_readdatavalid = s1_rvalid_q;
  assign s2_readdata      = s2_rdata_q;
  assign s2_readdatavalid = s2_rvalid_q;

endmodule

// File: tb/tb_vga_system_ram_dp.sv
// Directed bench for vga_system_ram_dp: byte-enabled writes, pipelined reads,
// s2 read-during-write, full clear timing, s1 stall during clear, reset abort
// mid-fill, and power-up clear on a small second instance.
module tb_vga_system_ram_dp;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;

  logic [AW-1:0] s1_address = '0;
  logic          s1_chipselect = 1'b0;
  logic          s1_read = 1'b0;
  logic          s1_write = 1'b0;
  logic [3:0]    s1_byteenable = '0;
  logic [DW-1:0] s1_writedata = '0;
  logic [DW-1:0] s1_readdata;
  logic          s1_readdatavalid;
  logic          s1_waitrequest;
  logic [AW-1:0] s2_address = '0;
  logic          s2_read = 1'b0;
  logic [DW-1:0] s2_readdata;
  logic          s2_readdatavalid;
  logic          clear_start = 1'b0;
  logic [DW-1:0] clear_value = '0;
  logic          clear_busy;
  logic          clear_done;

  // Second instance: 16 words, clears itself after reset.
  logic [3:0]    b_address = '0;
  logic          b_chipselect = 1'b0;
  logic          b_read = 1'b0;
  logic [DW-1:0] b_readdata;
  logic          b_readdatavalid;
  logic          b_waitrequest;
  logic [DW-1:0] b_s2_readdata;
  logic          b_s2_readdatavalid;
  logic          b_busy;
  logic          b_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_system_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(0)) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .s1_address       (s1_address),
    .s1_chipselect    (s1_chipselect),
    .s1_read          (s1_read),
    .s1_write         (s1_write),
    .s1_byteenable    (s1_byteenable),
    .s1_writedata     (s1_writedata),
    .s1_readdata      (s1_readdata),
    .s1_readdatavalid (s1_readdatavalid),
    .s1_waitrequest   (s1_waitrequest),
    .s2_address       (s2_address),
    .s2_read          (s2_read),
    .s2_readdata      (s2_readdata),
    .s2_readdatavalid (s2_readdatavalid),
    .clear_start      (clear_start),
    .clear_value      (clear_value),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done)
  );

  vga_system_ram_dp #(.DATA_W(DW), .ADDR_W(4), .CLEAR_ON_RESET(1)) u_dut_por (
    .clk              (clk),
    .reset_n          (reset_n),
    .s1_address       (b_address),
    .s1_chipselect    (b_chipselect),
    .s1_read          (b_read),
    .s1_write         (1'b0),
    .s1_byteenable    (4'h0),
    .s1_writedata     (32'h0),
    .s1_readdata      (b_readdata),
    .s1_readdatavalid (b_readdatavalid),
    .s1_waitrequest   (b_waitrequest),
    .s2_address       (4'h0),
    .s2_read          (1'b0),
    .s2_readdata      (b_s2_readdata),
    .s2_readdatavalid (b_s2_readdatavalid),
    .clear_start      (1'b0),
    .clear_value      (32'h0),
    .clear_busy       (b_busy),
    .clear_done       (b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s1_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0;
    s1_address = a; s1_writedata = d; s1_byteenable = be;
    tick();
    s1_chipselect = 1'b0; s1_write = 1'b0;
  endtask

  task automatic s1_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0; s1_address = a;
    tick();
    s1_chipselect = 1'b0; s1_read = 1'b0;
    check({tag, "_valid"}, {31'd0, s1_readdatavalid}, 32'd1);
    check({tag, "_data"}, s1_readdata, exp);
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int done_n;
    int wreq_err;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("rst_s1_valid", {31'd0, s1_readdatavalid}, 32'd0);
    check("rst_s1_data", s1_readdata, 32'd0);
    check("rst_s2_valid", {31'd0, s2_readdatavalid}, 32'd0);
    check("rst_busy", {31'd0, clear_busy}, 32'd0);
    check("rst_done", {31'd0, clear_done}, 32'd0);
    check("rst_wreq", {31'd0, s1_waitrequest}, 32'd0);
    check("rst_por_busy", {31'd0, b_busy}, 32'd0);
    reset_n = 1'b1;

    // ---------------- power-up clear on small instance ----------------
    tick();
    check("por_busy_first_edge", {31'd0, b_busy}, 32'd1);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!b_busy) break;
      busy_cnt++;
      tick();
    end
    check("por_busy_cycles", busy_cnt, 32'd17);
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 4'd3;
    tick();
    check("por_rd3_valid", {31'd0, b_readdatavalid}, 32'd1);
    check("por_rd3_data", b_readdata, 32'd0);
    b_address = 4'd15;
    tick();
    check("por_rd15_data", b_readdata, 32'd0);
    b_chipselect = 1'b0; b_read = 1'b0;

    // ---------------- byte enables ----------------
    s1_wr(10'd5, 32'hDEADBEEF, 4'hF);
    s1_wr(10'd5, 32'h000000AA, 4'h1);
    s1_rd("be_rd5", 10'd5, 32'hDEADBEAA);
    tick();
    check("idle_valid_low", {31'd0, s1_readdatavalid}, 32'd0);
    check("idle_data_held", s1_readdata, 32'hDEADBEAA);
    s1_wr(10'd6, 32'h11223344, 4'hF);
    s1_wr(10'd6, 32'hAABBCCDD, 4'hA);
    s1_rd("be_rd6", 10'd6, 32'hAA22CC44);

    // chipselect low: write ignored
    s1_chipselect = 1'b0; s1_write = 1'b1; s1_address = 10'd5;
    s1_writedata = 32'h0; s1_byteenable = 4'hF;
    tick();
    s1_write = 1'b0;
    s1_rd("cs_low_rd5", 10'd5, 32'hDEADBEAA);

    // ---------------- back-to-back reads ----------------
    s1_wr(10'd0, 32'hA0A0A0A0, 4'hF);
    s1_wr(10'd1, 32'hA1A1A1A1, 4'hF);
    s1_wr(10'd2, 32'hA2A2A2A2, 4'hF);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 10'd0;
    tick();
    check("b2b0_valid", {31'd0, s1_readdatavalid}, 32'd1);
    check("b2b0_data", s1_readdata, 32'hA0A0A0A0);
    s1_address = 10'd1;
    tick();
    check("b2b1_valid", {31'd0, s1_readdatavalid}, 32'd1);
    check("b2b1_data", s1_readdata, 32'hA1A1A1A1);
    s1_address = 10'd2;
    tick();
    check("b2b2_valid", {31'd0, s1_readdatavalid}, 32'd1);
    check("b2b2_data", s1_readdata, 32'hA2A2A2A2);
    s1_chipselect = 1'b0; s1_read = 1'b0;
    tick();
    check("b2b_end_valid", {31'd0, s1_readdatavalid}, 32'd0);

    // ---------------- read+write together is a write ----------------
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b1;
    s1_address = 10'd9; s1_writedata = 32'h55555555; s1_byteenable = 4'hF;
    tick();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    check("rw_no_valid", {31'd0, s1_readdatavalid}, 32'd0);
    s1_rd("rw_rd9", 10'd9, 32'h55555555);

    // ---------------- s2 read during s1 write returns old data ----------------
    s1_wr(10'd7, 32'h00000077, 4'hF);
    s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 10'd7;
    s1_writedata = 32'h00000011; s1_byteenable = 4'hF;
    s2_read = 1'b1; s2_address = 10'd7;
    tick();
    s1_chipselect = 1'b0; s1_write = 1'b0;
    check("s2_rdw_valid", {31'd0, s2_readdatavalid}, 32'd1);
    check("s2_rdw_old", s2_readdata, 32'h00000077);
    tick();
    check("s2_next_new", s2_readdata, 32'h00000011);
    s2_read = 1'b0;
    tick();
    check("s2_idle_valid", {31'd0, s2_readdatavalid}, 32'd0);
    check("s2_idle_held", s2_readdata, 32'h00000011);

    // ---------------- full clear, with s1 read on the start cycle ----------------
    clear_start = 1'b1; clear_value = 32'h12345678;
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_address = 10'd5;
    tick();
    clear_start = 1'b0; clear_value = 32'h0;
    s1_chipselect = 1'b0; s1_read = 1'b0;
    check("start_rd_valid", {31'd0, s1_readdatavalid}, 32'd1);
    check("start_rd_data", s1_readdata, 32'hDEADBEAA);
    busy_cnt = 0; done_at = 0; done_n = 0; wreq_err = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!clear_busy) break;
      busy_cnt++;
      if (clear_done) begin
        done_at = busy_cnt;
        done_n++;
      end
      if (s1_waitrequest !== 1'b1) wreq_err++;
      if (busy_cnt == 6) begin
        check("s2_during_fill", s2_readdata, 32'h12345678);
        s2_read = 1'b0;
      end
      if (busy_cnt == 5) begin
        s2_read = 1'b1; s2_address = 10'd0;
      end
      if (busy_cnt == 10) begin
        s1_chipselect = 1'b1; s1_write = 1'b1; s1_address = 10'd20;
        s1_writedata = 32'h20202020; s1_byteenable = 4'hF;
      end
      clear_start = (busy_cnt == 20);
      clear_value = 32'h99999999;
      tick();
    end
    clear_start = 1'b0;
    check("clear_busy_cycles", busy_cnt, 32'd1025);
    check("clear_done_cycle", done_at, 32'd1025);
    check("clear_done_pulses", done_n, 32'd1);
    check("wreq_during_fill", wreq_err, 32'd0);
    check("wreq_idle", {31'd0, s1_waitrequest}, 32'd0);
    // held write is accepted now that the engine is idle
    tick();
    s1_chipselect = 1'b0; s1_write = 1'b0;
    s1_rd("held_wr_rd20", 10'd20, 32'h20202020);
    s1_rd("clear_rd0", 10'd0, 32'h12345678);
    s1_rd("clear_rd1023", 10'd1023, 32'h12345678);
    s1_rd("clear_rd5", 10'd5, 32'h12345678);

    // ---------------- reset mid-fill at pointer 300 ----------------
    s1_wr(10'd299, 32'hAAAA0299, 4'hF);
    s1_wr(10'd300, 32'hBBBB0300, 4'hF);
    s2_read = 1'b1; s2_address = 10'd300;
    tick();
    s2_read = 1'b0;
    check("pre_rst_s2", s2_readdata, 32'hBBBB0300);
    clear_start = 1'b1; clear_value = 32'h0BADF00D;
    tick();
    clear_start = 1'b0; clear_value = 32'h0;
    repeat (300) tick();
    check("mid_busy", {31'd0, clear_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, clear_busy}, 32'd0);
    check("abort_wreq", {31'd0, s1_waitrequest}, 32'd0);
    check("abort_done", {31'd0, clear_done}, 32'd0);
    check("abort_s1_data", s1_readdata, 32'd0);
    check("abort_s2_data", s2_readdata, 32'd0);
    check("abort_s2_valid", {31'd0, s2_readdatavalid}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, clear_busy}, 32'd0);
    s1_rd("abort_rd0", 10'd0, 32'h0BADF00D);
    s1_rd("abort_rd299", 10'd299, 32'h0BADF00D);
    s1_rd("abort_rd300", 10'd300, 32'hBBBB0300);
    s1_rd("abort_rd1023", 10'd1023, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
